spell_mem_arbiter: RTL and testbench

SPELL_MEM_ARBITER -- requirements
Module: spell_mem_arbiter

---
 rtl/spell_mem_arbiter_pkg.sv | 19 +
 rtl/spell_rr_arbiter2.sv | 39 +++
 rtl/spell_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_spell_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spell_mem_arbiter_pkg.sv
// Shared definitions for the spell memory arbiter: memory type codes and the
// request bundle that gets latched onto the shared memory bus.
package spell_mem_arbiter_pkg;

   localparam logic [1:0] MemoryTypeData = 2'b00;
   localparam logic [1:0] MemoryTypeCode = 2'b01;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
      logic [1:0] mtype;
      logic       write;
   } mem_req_t;

   function automatic logic is_valid_mem_type(input logic [1:0] mtype);
      return (mtype == MemoryTypeData) || (mtype == MemoryTypeCode);
   endfunction

endpackage

// File: rtl/spell_rr_arbiter2.sv
// Two-way round-robin pick. A tie goes to the port that was not granted last;
// the last-grant register only moves when the caller commits the pick.
module spell_rr_arbiter2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant_valid,
   output logic       grant_idx
);

   logic last_q;
   logic last_d;

   always_comb begin
      grant_valid = |req;
      grant_idx   = 1'b0;
      case (req)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last_q;
         default: grant_idx = 1'b0;
      endcase
      last_d = last_q;
      if (advance && grant_valid) begin
         last_d = grant_idx;
      end
   end

   // Port 1 counts as last granted out of reset so port 0 wins the first tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/spell_mem_arbiter.sv
// Arbitrates two requesters onto one shared memory port: round-robin grant,
// one access in flight, per-access timeout, and an invalid-type fast error path.
module spell_mem_arbiter
   import spell_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic       clock,
   input  logic       reset,

   input  logic       p0_select,
   input  logic [7:0] p0_addr,
   input  logic [7:0] p0_data_in,
   input  logic [1:0] p0_memory_type,
   input  logic       p0_write,
   output logic [7:0] p0_data_out,
   output logic       p0_data_ready,
   output logic       p0_error,

   input  logic       p1_select,
   input  logic [7:0] p1_addr,
   input  logic [7:0] p1_data_in,
   input  logic [1:0] p1_memory_type,
   input  logic       p1_write,
   output logic [7:0] p1_data_out,
   output logic       p1_data_ready,
   output logic       p1_error,

   output logic       mem_select,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_data_in,
   output logic [1:0] mem_memory_type,
   output logic       mem_write,
   input  logic [7:0] mem_data_out,
   input  logic       mem_data_ready
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   arb_state_e state_q, state_d;
   logic       gnt_q, gnt_d;
   logic [7:0] cnt_q, cnt_d;
   logic       msel_q, msel_d;
   mem_req_t   mreq_q, mreq_d;
   logic [7:0] dout_q [2];
   logic [7:0] dout_d [2];
   logic [1:0] rdy_q, rdy_d;
   logic [1:0] err_q, err_d;

   mem_req_t   port_req [2];
   logic       arb_valid;
   logic       arb_idx;
   logic       arb_advance;
   logic       sel_granted;

   spell_rr_arbiter2 u_rr (
      .clock       (clock),
      .reset       (reset),
      .req         ({p1_select, p0_select}),
      .advance     (arb_advance),
      .grant_valid (arb_valid),
      .grant_idx   (arb_idx)
   );

   always_comb begin
      port_req[0] = '{addr: p0_addr, data: p0_data_in, mtype: p0_memory_type, write: p0_write};
      port_req[1] = '{addr: p1_addr, data: p1_data_in, mtype: p1_memory_type, write: p1_write};
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      msel_d      = msel_q;
      mreq_d      = mreq_q;
      dout_d      = dout_q;
      rdy_d       = rdy_q;
      err_d       = err_q;
      arb_advance = 1'b0;
      sel_granted = gnt_q ? p1_select : p0_select;

      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               arb_advance = 1'b1;
               gnt_d       = arb_idx;
               if (is_valid_mem_type(port_req[arb_idx].mtype)) begin
                  mreq_d  = port_req[arb_idx];
                  msel_d  = 1'b1;
                  cnt_d   = 8'd0;
                  state_d = ST_ACCESS;
               end else begin
                  rdy_d[arb_idx]  = 1'b1;
                  err_d[arb_idx]  = 1'b1;
                  dout_d[arb_idx] = 8'h00;
                  state_d         = ST_RELEASE;
               end
            end
         end

         // A dropped request wins over a same-edge memory response: the
         // requester has walked away, so nothing is reported back.
         ST_ACCESS: begin
            if (!sel_granted) begin
               msel_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (mem_data_ready) begin
               msel_d = 1'b0;
               if (!mreq_q.write) begin
                  dout_d[gnt_q] = mem_data_out;
               end
               rdy_d[gnt_q] = 1'b1;
               err_d[gnt_q] = 1'b0;
               state_d      = ST_RELEASE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               msel_d        = 1'b0;
               rdy_d[gnt_q]  = 1'b1;
               err_d[gnt_q]  = 1'b1;
               dout_d[gnt_q] = 8'h00;
               state_d       = ST_RELEASE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_RELEASE: begin
            msel_d = 1'b0;
            if (!sel_granted) begin
               rdy_d[gnt_q] = 1'b0;
               err_d[gnt_q] = 1'b0;
               state_d      = ST_IDLE;
            end
         end

         default: begin
            msel_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 1'b0;
         cnt_q     <= 8'd0;
         msel_q    <= 1'b0;
         mreq_q    <= '0;
         dout_q[0] <= 8'h00;
         dout_q[1] <= 8'h00;
         rdy_q     <= 2'b00;
         err_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         msel_q    <= msel_d;
         mreq_q    <= mreq_d;
         dout_q[0] <= dout_d[0];
         dout_q[1] <= dout_d[1];
         rdy_q     <= rdy_d;
         err_q     <= err_d;
      end
   end

   assign mem_select      = msel_q;
   assign mem_addr        = mreq_q.addr;
   assign mem_data_in     = mreq_q.data;
   assign mem_memory_type = mreq_q.mtype;
   assign mem_write       = mreq_q.write;

   assign p0_data_out   = dout_q[0];
   assign p0_data_ready = rdy_q[0];
   assign p0_error      = err_q[0];
   assign p1_data_out   = dout_q[1];
   assign p1_data_ready = rdy_q[1];
   assign p1_error      = err_q[1];

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Directed bench for spell_mem_arbiter with a small behavioural memory that
// answers a configurable number of cycles after mem_select rises.
module tb_spell_mem_arbiter;
   import spell_mem_arbiter_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sel   [2];
   logic [7:0] addr  [2];
   logic [7:0] din   [2];
   logic [1:0] mtype [2];
   logic       wr    [2];
   wire  [7:0] dout0, dout1;
   wire  [1:0] rdy, err;
   wire        mem_select, mem_write;
   wire  [7:0] mem_addr, mem_data_in;
   wire  [1:0] mem_memory_type;
   logic [7:0] mem_data_out = 8'h00;
   logic       mem_data_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   spell_mem_arbiter #(.TIMEOUT_CYCLES(15)) dut (
      .clock(clock), .reset(reset),
      .p0_select(sel[0]), .p0_addr(addr[0]), .p0_data_in(din[0]),
      .p0_memory_type(mtype[0]), .p0_write(wr[0]),
      .p0_data_out(dout0), .p0_data_ready(rdy[0]), .p0_error(err[0]),
      .p1_select(sel[1]), .p1_addr(addr[1]), .p1_data_in(din[1]),
      .p1_memory_type(mtype[1]), .p1_write(wr[1]),
      .p1_data_out(dout1), .p1_data_ready(rdy[1]), .p1_error(err[1]),
      .mem_select(mem_select), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_memory_type(mem_memory_type), .mem_write(mem_write),
      .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready)
   );

   always #5 clock = ~clock;

   // Behavioural memory: one bank per valid type, answers after mdelay cycles
   // (mdelay == 0 means it never answers).
   logic [7:0] mem_arr [2][256];
   int mdelay = 4;
   int mcnt = 0;
   always @(negedge clock) begin
      if (!mem_select) begin
         mcnt = 0;
         mem_data_ready = 1'b0;
      end else begin
         mcnt++;
         if (mdelay != 0 && mcnt == mdelay) begin
            mem_data_ready = 1'b1;
            if (mem_write) mem_arr[mem_memory_type[0]][mem_addr] = mem_data_in;
            else           mem_data_out = mem_arr[mem_memory_type[0]][mem_addr];
         end else begin
            mem_data_ready = 1'b0;
         end
      end
   end

   // Bus monitor: counts mem_select rises and bus changes while selected.
   logic       prev_sel = 1'b0;
   logic [18:0] prev_bus = '0;
   int rises = 0;
   int unstable = 0;
   always @(negedge clock) begin
      if (mem_select && !prev_sel) rises++;
      if (mem_select && prev_sel &&
          {mem_addr, mem_data_in, mem_memory_type, mem_write} != prev_bus) unstable++;
      prev_sel = mem_select;
      prev_bus = {mem_addr, mem_data_in, mem_memory_type, mem_write};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic raise(input int p, input logic [7:0] a, input logic [7:0] d,
                        input logic [1:0] t, input logic w);
      addr[p] = a; din[p] = d; mtype[p] = t; wr[p] = w; sel[p] = 1'b1;
   endtask

   task automatic wait_rdy(input int p, input int budget, output int n, output int msel_at);
      n = 0;
      msel_at = 0;
      while (n < budget) begin
         @(negedge clock);
         n++;
         if (mem_select && msel_at == 0) msel_at = n;
         if (rdy[p]) break;
      end
   endtask

   task automatic drop(input int p);
      sel[p] = 1'b0;
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, ms, rb;
      for (int p = 0; p < 2; p++) begin
         sel[p] = 1'b0; addr[p] = 8'h00; din[p] = 8'h00; mtype[p] = 2'b00; wr[p] = 1'b0;
      end
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 256; a++) mem_arr[b][a] = 8'h00;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      chk("rst_mem_select", mem_select, 1'b0);
      chk("rst_mem_addr", mem_addr, 8'h00);
      chk("rst_rdy", rdy, 2'b00);
      chk("rst_err", err, 2'b00);
      chk("rst_dout0", dout0, 8'h00);
      chk("rst_dout1", dout1, 8'h00);

      // Single read, 4-cycle memory
      mem_arr[0][8'h10] = 8'h5A;
      raise(0, 8'h10, 8'h00, MemoryTypeData, 1'b0);
      wait_rdy(0, 40, n, ms);
      chk("rd_msel_lat", ms, 1);
      chk("rd_rdy_lat", n, 5);
      chk("rd_dout0", dout0, 8'h5A);
      chk("rd_err0", err[0], 1'b0);
      chk("rd_rdy1_idle", rdy[1], 1'b0);
      drop(0);
      chk("rd_release", rdy[0], 1'b0);

      // Tie straight after reset: p0 first, then p1
      do_reset();
      mem_arr[0][8'h30] = 8'h11;
      mem_arr[0][8'h31] = 8'h22;
      raise(0, 8'h30, 8'h00, MemoryTypeData, 1'b0);
      raise(1, 8'h31, 8'h00, MemoryTypeData, 1'b0);
      wait_rdy(0, 40, n, ms);
      chk("tie1_p0_lat", n, 5);
      chk("tie1_p0_dout", dout0, 8'h11);
      chk("tie1_p1_waits", rdy[1], 1'b0);
      drop(0);
      wait_rdy(1, 40, n, ms);
      chk("tie1_p1_lat", n, 5);
      chk("tie1_p1_dout", dout1, 8'h22);
      chk("tie1_p0_quiet", rdy[0], 1'b0);
      drop(1);

      // p0 alone, then a tie: p1 now wins
      mem_arr[0][8'h40] = 8'h33;
      raise(0, 8'h40, 8'h00, MemoryTypeData, 1'b0);
      wait_rdy(0, 40, n, ms);
      chk("solo_p0_dout", dout0, 8'h33);
      drop(0);
      mem_arr[0][8'h50] = 8'h44;
      mem_arr[0][8'h51] = 8'h55;
      raise(0, 8'h50, 8'h00, MemoryTypeData, 1'b0);
      raise(1, 8'h51, 8'h00, MemoryTypeData, 1'b0);
      wait_rdy(1, 40, n, ms);
      chk("tie2_p1_lat", n, 5);
      chk("tie2_p1_dout", dout1, 8'h55);
      chk("tie2_p0_waits", rdy[0], 1'b0);
      drop(1);
      wait_rdy(0, 40, n, ms);
      chk("tie2_p0_lat", n, 5);
      chk("tie2_p0_dout", dout0, 8'h44);
      drop(0);

      // p1 writes Code 0x22, p0 reads it back
      rb = rises;
      raise(1, 8'h22, 8'hA5, MemoryTypeCode, 1'b1);
      wait_rdy(1, 40, n, ms);
      chk("wr_lat", n, 5);
      chk("wr_err1", err[1], 1'b0);
      chk("wr_dout1_kept", dout1, 8'h55);
      chk("wr_landed", mem_arr[1][8'h22], 8'hA5);
      drop(1);
      raise(0, 8'h22, 8'h00, MemoryTypeCode, 1'b0);
      wait_rdy(0, 40, n, ms);
      chk("rdback_dout0", dout0, 8'hA5);
      drop(0);
      chk("wr_rd_two_rises", rises - rb, 2);

      // Invalid memory type
      rb = rises;
      raise(0, 8'h80, 8'h00, 2'b11, 1'b0);
      wait_rdy(0, 10, n, ms);
      chk("inv_lat", n, 1);
      chk("inv_err0", err[0], 1'b1);
      chk("inv_dout0", dout0, 8'h00);
      drop(0);
      chk("inv_release_rdy", rdy[0], 1'b0);
      chk("inv_release_err", err[0], 1'b0);
      chk("inv_no_msel", rises - rb, 0);

      // Timeout: memory never answers
      mdelay = 0;
      raise(1, 8'h60, 8'h00, MemoryTypeData, 1'b0);
      wait_rdy(1, 40, n, ms);
      chk("to_lat", n, 16);
      chk("to_msel_low", mem_select, 1'b0);
      chk("to_err1", err[1], 1'b1);
      chk("to_dout1", dout1, 8'h00);
      drop(1);

      // Reset during ACCESS
      raise(0, 8'h60, 8'h00, MemoryTypeData, 1'b0);
      repeat (3) @(negedge clock);
      chk("rstmid_msel_high", mem_select, 1'b1);
      reset = 1'b1;
      sel[0] = 1'b0;
      @(negedge clock);
      chk("rstmid_msel", mem_select, 1'b0);
      chk("rstmid_rdy", rdy, 2'b00);
      reset = 1'b0;
      @(negedge clock);

      // Requester abandons during ACCESS, then a fresh request is granted at once
      raise(0, 8'h61, 8'h00, MemoryTypeData, 1'b0);
      repeat (3) @(negedge clock);
      sel[0] = 1'b0;
      @(negedge clock);
      chk("abn_msel", mem_select, 1'b0);
      chk("abn_rdy0", rdy[0], 1'b0);
      mdelay = 4;
      mem_arr[0][8'h70] = 8'h66;
      raise(1, 8'h70, 8'h00, MemoryTypeData, 1'b0);
      wait_rdy(1, 40, n, ms);
      chk("abn_idle_msel_lat", ms, 1);
      chk("abn_idle_rdy_lat", n, 5);
      chk("abn_p1_dout", dout1, 8'h66);
      chk("abn_rdy0_still", rdy[0], 1'b0);
      drop(1);

      chk("bus_stable", unstable, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
